// File: rtl/bitunreverse_if.sv
// Sample-stream bundle for bitunreverse. The producer of bit-reversed samples
// uses the master view, and the reorder block uses the slave view.
interface bitunreverse_if #(
  parameter int WIDTH = 24
);
  logic                 i_ce;
  logic                 i_sync;
  logic [2*WIDTH-1:0]   i_in;
  logic [2*WIDTH-1:0]   o_out;
  logic                 o_sync;

  modport master (
    output i_ce,
    output i_sync,
    output i_in,
    input  o_out,
    input  o_sync
  );

  modport slave (
    input  i_ce,
    input  i_sync,
    input  i_in,
    output o_out,
    output o_sync
  );
endinterface

// File: rtl/bitunreverse.sv
// Ping-pong frame buffer that turns a bit-reversed FFT output stream back into
// natural order. One bank is written while the other is read.
module bitunreverse #(
  parameter int LGSIZE = 5,
  parameter int WIDTH  = 24
) (
  input  logic            i_clk,
  input  logic            i_reset,
  bitunreverse_if.slave   bus
);
  localparam int N  = 1 << LGSIZE;
  localparam int SW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state_q, state_d;
  logic [LGSIZE-1:0]   cnt_q, cnt_d;
  logic                wbank_q, wbank_d;
  logic [SW-1:0]       out_q;
  logic                sync_q, sync_d;

  logic [SW-1:0]       mem [2*N];

  logic [LGSIZE-1:0]   idx;
  logic                resync;
  logic                wb;
  logic                last;
  logic                wr_en;
  logic                rd_en;
  logic [LGSIZE:0]     waddr;
  logic [LGSIZE:0]     raddr;

  function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
    logic [LGSIZE-1:0] r;
    for (int b = 0; b < LGSIZE; b++) begin
      r[b] = v[LGSIZE-1-b];
    end
    return r;
  endfunction

  // A sync that lands mid-frame abandons the partial frame by jumping banks.
  always_comb begin
    idx    = bus.i_sync ? '0 : cnt_q;
    resync = bus.i_sync && (state_q != IDLE) && (cnt_q != '0);
    wb     = resync ? ~wbank_q : wbank_q;
    last   = &idx;
    waddr  = {wb, bitrev(idx)};
    raddr  = {~wb, idx};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wbank_d = wbank_q;
    sync_d  = sync_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    if (bus.i_ce) begin
      case (state_q)
        IDLE: begin
          sync_d = 1'b0;
          if (bus.i_sync) begin
            wr_en   = 1'b1;
            cnt_d   = LGSIZE'(1);
            wbank_d = 1'b0;
            state_d = FILL;
          end
        end
        default: begin
          wr_en   = 1'b1;
          rd_en   = 1'b1;
          cnt_d   = idx + LGSIZE'(1);
          wbank_d = last ? ~wb : wb;
          sync_d  = (state_q == RUN) && !resync && (idx == '0);
          if (resync) begin
            state_d = FILL;
          end else if ((state_q == FILL) && last) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[waddr] <= bus.i_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wbank_q <= 1'b0;
      sync_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wbank_q <= wbank_d;
      sync_q  <= sync_d;
      if (rd_en) begin
        out_q <= mem[raddr];
      end
    end
  end

  assign bus.o_out  = out_q;
  assign bus.o_sync = sync_q;
endmodule

// File: tb/tb_bitunreverse.sv
// Directed bench for bitunreverse (LGSIZE=3, WIDTH=4) with a queue-based
// scoreboard; each sample is {frame number, natural index}.
module tb_bitunreverse;
  logic clk;
  logic rst;

  bitunreverse_if #(.WIDTH(4)) ifc ();

  bitunreverse #(.LGSIZE(3), .WIDTH(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifc)
  );

  typedef struct {
    logic       s;
    logic       c;
    logic [7:0] d;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic have_cur;
  logic last_ce;
  logic last_rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] br3(input logic [2:0] p);
    return {1'b0, p[0], p[1], p[2]};
  endfunction

  always @(posedge clk) begin
    last_ce  <= ifc.i_ce;
    last_rst <= rst;
  end

  // Pops one expectation per strobe or reset edge; otherwise outputs must hold.
  always @(negedge clk) begin
    if (last_rst || last_ce) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL underflow: output strobe with no expectation queued (o_sync=%0b o_out=%h)",
                 ifc.o_sync, ifc.o_out);
      end else begin
        cur = q.pop_front();
        have_cur = 1'b1;
        if (ifc.o_sync !== cur.s) begin
          failures++;
          $display("FAIL %s o_sync: got %0b expected %0b", cur.tag, ifc.o_sync, cur.s);
        end
        if (cur.c) begin
          checks++;
          if (ifc.o_out !== cur.d) begin
            failures++;
            $display("FAIL %s o_out: got %h expected %h", cur.tag, ifc.o_out, cur.d);
          end
        end
      end
    end else if (have_cur) begin
      checks++;
      if (ifc.o_sync !== cur.s) begin
        failures++;
        $display("FAIL %s hold o_sync: got %0b expected %0b", cur.tag, ifc.o_sync, cur.s);
      end
      if (cur.c && (ifc.o_out !== cur.d)) begin
        failures++;
        $display("FAIL %s hold o_out: got %h expected %h", cur.tag, ifc.o_out, cur.d);
      end
    end
  end

  task automatic cyc(input logic rst_v, input logic ce, input logic sy, input logic [7:0] din,
                     input logic es, input logic ec, input logic [7:0] eo, input string tag);
    exp_t e;
    if (rst_v || ce) begin
      e.s = es; e.c = ec; e.d = eo; e.tag = tag;
      q.push_back(e);
    end
    rst        = rst_v;
    ifc.i_ce   = ce;
    ifc.i_sync = sy;
    ifc.i_in   = din;
    @(posedge clk);
    #1;
  endtask

  // Sends the first n samples of frame f in bit-reversed order; when ev is set
  // the output must show frame pf in natural order.
  task automatic frame(input logic [3:0] f, input logic sy, input logic [3:0] pf,
                       input logic ev, input int gap, input int n, input string tag);
    for (int p = 0; p < n; p++) begin
      cyc(1'b0, 1'b1, sy && (p == 0), {f, br3(3'(p))},
          ev && (p == 0), ev, {pf, 4'(p)}, tag);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 1'b0, 1'b0, 8'hxx, 1'b0, 1'b0, 8'h00, tag);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    have_cur = 1'b0;
    last_ce  = 1'b0;
    last_rst = 1'b0;
    rst        = 1'b1;
    ifc.i_ce   = 1'b0;
    ifc.i_sync = 1'b0;
    ifc.i_in   = '0;

    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, "reset");
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, "reset");

    frame(4'd0, 1'b1, 4'd0, 1'b0, 0, 8, "fill0");
    frame(4'd1, 1'b1, 4'd0, 1'b1, 0, 8, "run1");
    frame(4'd2, 1'b1, 4'd1, 1'b1, 0, 8, "run2");

    frame(4'd3, 1'b1, 4'd2, 1'b1, 2, 8, "cegap3");
    frame(4'd4, 1'b1, 4'd3, 1'b1, 2, 8, "cegap4");

    frame(4'd5, 1'b1, 4'd4, 1'b1, 0, 5, "partial5");
    frame(4'd6, 1'b1, 4'd0, 1'b0, 0, 8, "resync6");
    frame(4'd7, 1'b1, 4'd6, 1'b1, 0, 8, "after7");

    frame(4'd8,  1'b0, 4'd7, 1'b1, 0, 8, "free8");
    frame(4'd9,  1'b0, 4'd8, 1'b1, 0, 8, "free9");
    frame(4'd10, 1'b0, 4'd9, 1'b1, 0, 8, "free10");

    frame(4'd11, 1'b1, 4'd10, 1'b1, 0, 3, "pre_rst11");
    cyc(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 8'h00, "midreset");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h00, "idle_discard");
    end
    frame(4'd12, 1'b1, 4'd0, 1'b0, 0, 8, "refill12");
    frame(4'd13, 1'b1, 4'd12, 1'b1, 0, 8, "rerun13");
    frame(4'd14, 1'b1, 4'd13, 1'b1, 0, 8, "rerun14");

    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "drain");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
